// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - state_e : FSM state encoding (IDLE / SHIFT / DONE)
//   - clog2() : ceiling log2, used to size the bit counter
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Ceiling log2 of a positive value; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// -----------------------------------------------------------------------------
// serial_fa_bit
// Single-bit full adder built from two half-adder stages and an OR.
// Purely combinational.
// Ports:
//   a    in  1  operand bit A
//   b    in  1  operand bit B
//   cin  in  1  carry in
//   s    out 1  sum bit
//   cout out 1  carry out
// -----------------------------------------------------------------------------
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha1_s_s;
    logic ha1_c_s;
    logic ha2_c_s;

    // First half adder: a + b.
    assign ha1_s_s = a ^ b;
    assign ha1_c_s = a & b;

    // Second half adder: partial sum + carry in.
    assign s       = ha1_s_s ^ cin;
    assign ha2_c_s = ha1_s_s & cin;

    // The two half-adder carries can never both be set, so OR merges them.
    assign cout    = ha1_c_s | ha2_c_s;

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial two-operand adder. Operands are accepted on a valid/ready
// handshake, added LSB-first one bit per clock through a single full-adder
// cell with a registered carry, and the WIDTH-bit result is presented with
// out_valid until the consumer accepts it.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN): adds the 'sub' port; when a
// captured sub=1 the B bits are inverted and the carry starts at 1, giving
// a-b (carry_out=1 means no borrow).
//
// Parameters:
//   WIDTH      operand/sum width, 2..32
// Ports:
//   CLK        in   1      clock, rising edge
//   Reset      in   1      synchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      ready to accept operands (IDLE, not in reset)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      subtract select (SERIAL_ADDER_SUB_EN only)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   carry_out  out  1      carry out of the MSB
//   busy       out  1      high in SHIFT or DONE
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int             CNT_W    = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   a_sr_q,      a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,      b_sr_d;
    logic [WIDTH-1:0]   res_q,       res_d;
    logic               carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               cout_q,      cout_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic               b_bit_s;
    logic               carry_init_s;
    logic               fa_s_s;
    logic               fa_c_s;
    logic [WIDTH-1:0]   res_shift_s;

`ifdef SERIAL_ADDER_SUB_EN
    logic               sub_q,       sub_d;

    // Subtraction = A + ~B + 1: invert B bits, seed the carry with the mode bit.
    assign b_bit_s      = b_sr_q[0] ^ sub_q;
    assign carry_init_s = sub;
`else
    assign b_bit_s      = b_sr_q[0];
    assign carry_init_s = 1'b0;
`endif

    serial_fa_bit u_fa (
        .a    (a_sr_q[0]),
        .b    (b_bit_s),
        .cin  (carry_q),
        .s    (fa_s_s),
        .cout (fa_c_s)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign res_shift_s = (res_q >> 1) | (fa_s_s ? MSB_ONE : {WIDTH{1'b0}});

    // Ready only in IDLE and never while reset is asserted.
    assign in_ready  = (state_q == ST_IDLE) && !Reset;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign busy      = busy_q;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    res_d   = {WIDTH{1'b0}};
                    carry_d = carry_init_s;
                    cnt_d   = {CNT_W{1'b0}};
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = res_shift_s;
                carry_d = fa_c_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish result and carry on the DONE-entry edge.
                    sum_d   = res_shift_s;
                    cout_d  = fa_c_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            a_sr_q      <= {WIDTH{1'b0}};
            b_sr_q      <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8): directed vector table,
// hand-written multi-cycle sequences, and random operands checked against
// plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    serial_adder #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_sum;
        logic         exp_c;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: plain arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] es, output logic ec);
        int unsigned r;
        if (msub) begin
            r  = (int'(ma) - int'(mb)) & 32'hFF;
            es = r[W-1:0];
            ec = (ma >= mb);
        end else begin
            r  = int'(ma) + int'(mb);
            es = r[W-1:0];
            ec = r[W];
        end
    endtask

    // One full transaction: handshake, latency check, optional hold in DONE
    // with junk in_valid, then result handshake and return to IDLE.
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tsub, input int hold,
                          input logic [W-1:0] es, input logic ec);
        int waitc;
        int lat;
        bit got;
        waitc = 0;
        while (!in_ready && waitc < 10) begin
            tick();
            waitc++;
        end
        check({nm, "_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_v; sub = tsub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        check({nm, "_busy"}, 32'(busy), 32'd1);
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (out_valid) got = 1'b1;
        end
        check({nm, "_latency"}, 32'(lat), 32'(W));
        check({nm, "_sum"}, 32'(sum), 32'(es));
        check({nm, "_carry"}, 32'(carry_out), 32'(ec));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = ~ta;
            tick();
            check({nm, "_hold_sum"}, 32'(sum), 32'(es));
            check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({nm, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, "_post_valid"}, 32'(out_valid), 32'd0);
        check({nm, "_post_ready"}, 32'(in_ready), 32'd1);
        check({nm, "_post_busy"}, 32'(busy), 32'd0);
        check({nm, "_post_sum"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rs, ec;
        int           seen;

        vecs[0] = '{8'h35, 8'h0A, 1'b0, 8'h3F, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; sub = 1'b0;

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_carry", 32'(carry_out), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        Reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("post_rst_in_ready2", 32'(in_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub, 0,
                   vecs[i].exp_sum, vecs[i].exp_c);
        end

        // Result held while consumer stalls for 5 cycles.
        run_op("stall", 8'h12, 8'h34, 1'b0, 5, 8'h46, 1'b0);
        run_op("after_stall", 8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0);

        // Reset during the SHIFT phase: abort, no result.
        a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_never_valid", 32'(seen), 32'd0);
        run_op("after_abort", 8'h12, 8'h34, 1'b0, 0, 8'h46, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_nob", 8'h10, 8'h01, 1'b1, 0, 8'h0F, 1'b1);
        run_op("sub_borrow", 8'h01, 8'h02, 1'b1, 0, 8'hFF, 1'b0);
`endif

        // Random operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rs, es, ec);
            run_op($sformatf("rand%0d", i), ra, rb, rs, int'($urandom_range(0, 3)), es, ec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
